// File: rtl/rv32i_types.sv
// Shared RV32I core types, including the branch history table counter and FSM encodings.
package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef logic [1:0] bht_ctr_t;

   localparam bht_ctr_t BHT_SNT = 2'b00;
   localparam bht_ctr_t BHT_WNT = 2'b01;
   localparam bht_ctr_t BHT_WT  = 2'b10;
   localparam bht_ctr_t BHT_ST  = 2'b11;

   typedef enum logic {BHT_INIT, BHT_READY} bht_state_t;

endpackage

// File: rtl/sat_ctr2.sv
// Two-bit saturating counter next-state function: count up on taken, down on not-taken.
module sat_ctr2
   import rv32i_types::*;
(
   input  bht_ctr_t ctr,
   input  logic     taken,
   output bht_ctr_t nxt
);

   always_comb begin
      nxt = ctr;
      if (taken) begin
         if (ctr != BHT_ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != BHT_SNT) nxt = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: 2-bit counters indexed by pc[IDX_BITS+1:2], swept to INIT_CTR after reset.
// Define BHT_PERF_CNT_EN to add perf_updates / perf_mispredicts counters.
module bht_predictor
   import rv32i_types::*;
#(
   parameter int       IDX_BITS = 6,
   parameter bht_ctr_t INIT_CTR = BHT_WNT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ready,
   input  logic        pred_valid,
   input  rv32i_word   pred_pc,
   output logic        pred_resp_valid,
   output logic        pred_taken,
   input  logic        upd_valid,
   input  rv32i_word   upd_pc,
   input  logic        upd_br_en,
   input  logic        upd_pred_taken,
`ifdef BHT_PERF_CNT_EN
   output logic [31:0] perf_updates,
   output logic [31:0] perf_mispredicts,
`endif
   output logic        mispredict
);

   localparam int ENTRIES = 2 ** IDX_BITS;

   bht_state_t          state;
   logic [IDX_BITS-1:0] init_idx;
   bht_ctr_t            bht_tbl [ENTRIES];

   logic [IDX_BITS-1:0] pred_idx, upd_idx, wr_idx;
   bht_ctr_t            upd_next, wr_data;
   logic                wr_en;

   assign pred_idx = pred_pc[IDX_BITS+1:2];
   assign upd_idx  = upd_pc[IDX_BITS+1:2];

   // PC offset bits and tag bits above the index are deliberately dropped (aliasing allowed).
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                             upd_pc[31:IDX_BITS+2],  upd_pc[1:0]};

   sat_ctr2 u_sat_ctr2 (
      .ctr   (bht_tbl[upd_idx]),
      .taken (upd_br_en),
      .nxt   (upd_next)
   );

   always_comb begin
      wr_en   = 1'b0;
      wr_idx  = init_idx;
      wr_data = INIT_CTR;
      if (!rst) begin
         if (state == BHT_INIT) begin
            wr_en = 1'b1;
         end else if (upd_valid) begin
            wr_en   = 1'b1;
            wr_idx  = upd_idx;
            wr_data = upd_next;
         end
      end
   end

   // Table has no reset; its contents only become meaningful once the sweep finishes.
   always_ff @(posedge clk) begin
      if (wr_en) bht_tbl[wr_idx] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= BHT_INIT;
         init_idx         <= '0;
         ready            <= 1'b0;
         pred_resp_valid  <= 1'b0;
         pred_taken       <= 1'b0;
         mispredict       <= 1'b0;
`ifdef BHT_PERF_CNT_EN
         perf_updates     <= '0;
         perf_mispredicts <= '0;
`endif
      end else begin
         pred_resp_valid <= 1'b0;
         mispredict      <= 1'b0;
         case (state)
            BHT_INIT: begin
               init_idx <= init_idx + IDX_BITS'(1);
               if (&init_idx) begin
                  state <= BHT_READY;
                  ready <= 1'b1;
               end
            end
            BHT_READY: begin
               // Table read sees the value before any same-edge update (no bypass).
               if (pred_valid) begin
                  pred_resp_valid <= 1'b1;
                  pred_taken      <= bht_tbl[pred_idx][1];
               end
               if (upd_valid) begin
                  mispredict <= (upd_br_en != upd_pred_taken);
`ifdef BHT_PERF_CNT_EN
                  perf_updates <= perf_updates + 32'd1;
                  if (upd_br_en != upd_pred_taken)
                     perf_mispredicts <= perf_mispredicts + 32'd1;
`endif
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: init sweep timing, training, saturation, aliasing, reset mid-sweep.
module tb_bht_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        ready;
   logic        pred_valid;
   logic [31:0] pred_pc;
   logic        pred_resp_valid;
   logic        pred_taken;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_br_en;
   logic        upd_pred_taken;
   logic        mispredict;
`ifdef BHT_PERF_CNT_EN
   logic [31:0] perf_updates;
   logic [31:0] perf_mispredicts;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   bht_predictor #(.IDX_BITS(6), .INIT_CTR(2'b01)) dut (
      .clk             (clk),
      .rst             (rst),
      .ready           (ready),
      .pred_valid      (pred_valid),
      .pred_pc         (pred_pc),
      .pred_resp_valid (pred_resp_valid),
      .pred_taken      (pred_taken),
      .upd_valid       (upd_valid),
      .upd_pc          (upd_pc),
      .upd_br_en       (upd_br_en),
      .upd_pred_taken  (upd_pred_taken),
`ifdef BHT_PERF_CNT_EN
      .perf_updates    (perf_updates),
      .perf_mispredicts(perf_mispredicts),
`endif
      .mispredict      (mispredict)
   );

   typedef struct {
      logic        pv;
      logic [31:0] ppc;
      logic        uv;
      logic [31:0] upc;
      logic        br;
      logic        ptk;
      logic        exp_rv;
      logic        exp_tk;
      logic        exp_mis;
   } vec_t;

   vec_t vecs [26];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0;
      upd_br_en = 0; upd_pred_taken = 0;
   endtask

   // Waits for ready with lookups and updates pending; counts cycles and stray outputs.
   task automatic wait_init(input string nm);
      int cnt = 0;
      int stray = 0;
      pred_valid = 1; pred_pc = 32'h60;
      upd_valid = 1; upd_pc = 32'h60; upd_br_en = 1; upd_pred_taken = 0;
      while (!ready && cnt < 200) begin
         if (pred_resp_valid || mispredict) stray++;
         cnt++;
         step();
      end
      idle();
      chk({nm, "_init_cycles"}, cnt, 64);
      chk({nm, "_stray_outputs"}, stray, 0);
   endtask

   initial begin
      int npulse;
      vecs[0]  = '{1, 32'h060, 0, 32'h000, 0, 0, 1, 0, 0};
      vecs[1]  = '{0, 32'h000, 1, 32'h060, 1, 0, 0, 0, 1};
      vecs[2]  = '{0, 32'h000, 1, 32'h060, 1, 1, 0, 0, 0};
      vecs[3]  = '{0, 32'h000, 1, 32'h060, 1, 1, 0, 0, 0};
      vecs[4]  = '{1, 32'h060, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[5]  = '{0, 32'h000, 1, 32'h060, 0, 1, 0, 1, 1};
      vecs[6]  = '{0, 32'h000, 1, 32'h060, 0, 1, 0, 1, 1};
      vecs[7]  = '{1, 32'h060, 0, 32'h000, 0, 0, 1, 0, 0};
      vecs[8]  = '{0, 32'h000, 1, 32'h060, 0, 0, 0, 0, 0};
      vecs[9]  = '{0, 32'h000, 1, 32'h060, 0, 0, 0, 0, 0};
      vecs[10] = '{0, 32'h000, 1, 32'h060, 1, 0, 0, 0, 1};
      vecs[11] = '{1, 32'h060, 0, 32'h000, 0, 0, 1, 0, 0};
      vecs[12] = '{0, 32'h000, 1, 32'h060, 1, 0, 0, 0, 1};
      vecs[13] = '{1, 32'h060, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[14] = '{1, 32'h100, 1, 32'h100, 1, 0, 1, 0, 1};
      vecs[15] = '{1, 32'h100, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[16] = '{0, 32'h000, 1, 32'h004, 1, 0, 0, 1, 1};
      vecs[17] = '{0, 32'h000, 1, 32'h004, 1, 1, 0, 1, 0};
      vecs[18] = '{1, 32'h104, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[19] = '{1, 32'h008, 0, 32'h000, 0, 0, 1, 0, 0};
      vecs[20] = '{1, 32'h107, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[21] = '{0, 32'h000, 1, 32'h010, 1, 0, 0, 1, 1};
      vecs[22] = '{0, 32'h000, 1, 32'h014, 1, 0, 0, 1, 1};
      vecs[23] = '{1, 32'h010, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[24] = '{1, 32'h014, 0, 32'h000, 0, 0, 1, 1, 0};
      vecs[25] = '{0, 32'h000, 0, 32'h000, 0, 0, 0, 1, 0};

      idle();
      rst = 1;
      step();
      rst = 0;
      chk("rst_ready", ready, 0);
      chk("rst_resp_valid", pred_resp_valid, 0);
      chk("rst_pred_taken", pred_taken, 0);
      chk("rst_mispredict", mispredict, 0);
`ifdef BHT_PERF_CNT_EN
      chk("rst_perf_updates", perf_updates, 0);
      chk("rst_perf_mispredicts", perf_mispredicts, 0);
`endif
      wait_init("first");

      foreach (vecs[i]) begin
         pred_valid = vecs[i].pv;  pred_pc = vecs[i].ppc;
         upd_valid = vecs[i].uv;   upd_pc = vecs[i].upc;
         upd_br_en = vecs[i].br;   upd_pred_taken = vecs[i].ptk;
         step();
         chk($sformatf("vec%0d_resp_valid", i), pred_resp_valid, vecs[i].exp_rv);
         chk($sformatf("vec%0d_pred_taken", i), pred_taken, vecs[i].exp_tk);
         chk($sformatf("vec%0d_mispredict", i), mispredict, vecs[i].exp_mis);
      end
      idle();

      // Reset in the middle of the sweep, with init_idx at 20.
      rst = 1;
      step();
      rst = 0;
      repeat (20) step();
      chk("midsweep_ready", ready, 0);
      rst = 1;
      step();
      rst = 0;
      chk("rerst_ready", ready, 0);
      chk("rerst_pred_taken", pred_taken, 0);
      wait_init("second");

      // 0x60 was trained to weakly-taken; the re-sweep must bring it back to 01.
      pred_valid = 1; pred_pc = 32'h60;
      step();
      idle();
      chk("reinit_resp_valid", pred_resp_valid, 1);
      chk("reinit_pred_taken", pred_taken, 0);
`ifdef BHT_PERF_CNT_EN
      chk("reinit_perf_updates", perf_updates, 0);
`endif

      // Five updates, two mispredicted; count the pulses.
      npulse = 0;
      for (int k = 0; k < 5; k++) begin
         upd_valid = 1; upd_pc = 32'h200 + 32'(k * 4);
         upd_br_en = (k != 2 && k != 3);
         upd_pred_taken = (k != 1 && k != 2);
         step();
         if (mispredict) npulse++;
      end
      idle();
      step();
      if (mispredict) npulse++;
      chk("perf_mis_pulses", npulse, 2);
`ifdef BHT_PERF_CNT_EN
      chk("perf_updates", perf_updates, 5);
      chk("perf_mispredicts", perf_mispredicts, 2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
